alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked ALU; successor to the 8-bit combinational ALU in the datapath.
//  Adds registered flags (C/Z/N/V), carry-chained ADC/SBB and iterative MUL/DIVU.
//  Sits between the register file read ports and the writeback stage.
//  Ops are accepted over a valid/ready input and results return over a valid/ready output.
// PARAMETERS
//  WIDTH     16   operand/result width (>=4)
//  OPW        4   op-code width (fixed encoding below)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept an op this cycle
//  op         in   OPW    operation code
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result/flags valid, held until out_ready
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  primary result (MUL low half / DIVU quotient)
//  result_hi  out  WIDTH  MUL high half / DIVU remainder; 0 for other ops
//  flag_c     out  1      carry/borrow (registered, persists between ops)
//  flag_z     out  1      result == 0
//  flag_n     out  1      result[WIDTH-1]
//  flag_v     out  1      signed overflow (ADD/SUB/ADC/SBB); divide-by-zero for DIVU
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, result_hi=0, all flags=0.
//   Any in-flight MUL/DIVU is discarded; no output produced for it.
//  Op codes: 0 ADD, 1 SUB (A-B), 2 SHR (A>>1, logical), 3 SHL (A<<1), 4 AND, 5 OR,
//   6 NOT (~A), 7 XOR, 8 ADC (A+B+C), 9 SBB (A-B-C), 10 MUL (unsigned, 2*WIDTH product),
//   11 DIVU (unsigned), 12-15 reserved: result=0, flag_z=1, other flags unchanged.
//  States: IDLE -> (accept single-cycle op) -> DONE; IDLE -> (accept MUL/DIVU) -> BUSY;
//   BUSY -> (after WIDTH iterations) -> DONE; DONE -> (out_ready) -> IDLE, or DONE again if
//   a new single-cycle op is accepted the same cycle, BUSY if new op is MUL/DIVU.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//  Latency: single-cycle ops out_valid the cycle after accept (throughput 1/clk when
//   out_ready held high); MUL/DIVU out_valid WIDTH+1 cycles after accept.
//  Operands/op captured at accept; later changes on a/b/op ignored.
//  out_valid & result stable while out_ready=0 (no drop, no overwrite).
//  Arithmetic: ADD/ADC C = carry out of WIDTH bits; SUB/SBB C = borrow (1 when A < B+Cin);
//   V = signed overflow of the WIDTH-bit op. SHR: C = A[0]; SHL: C = A[WIDTH-1].
//   Logic ops and NOT: C and V cleared. MUL: C = (result_hi != 0), V=0.
//  DIVU: restoring shift-subtract, one bit/cycle. B==0 -> result=all ones, result_hi=A,
//   V=1, C=0, still WIDTH+1 latency.  Z and N always from `result` only.
//  ADC/SBB use flag_c as registered at the end of the previous completed op.
//  Flags update only when a result becomes valid, not at accept.
// TESTING
//  1 WIDTH=16 ADD a=0xFFFF b=0x0001 -> result=0x0000, C=1, Z=1, V=0, latency 1.
//  2 ADD 0x7FFF+0x0001 -> 0x8000, N=1, V=1; then ADC 0x0000+0x0000 after carry-set ADD -> 0x0001.
//  3 MUL a=0xFFFF b=0xFFFF -> result=0x0001, result_hi=0xFFFE, C=1, out_valid 17 clks after accept.
//  4 DIVU a=100 b=7 -> result=14, result_hi=2; DIVU b=0 -> result=0xFFFF, result_hi=a, V=1.
//  5 out_ready=0 for 5 clks after SUB 3-5 -> result=0xFFFE, C=1 held, in_ready=0; back-to-back
//   ops with out_ready=1 complete one per clock.
//  6 Assert rst_n=0 mid-MUL (cycle 8) -> out_valid=0, flags=0 immediately; next op runs clean.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic ops plus iterative MUL/DIVU, with
// registered C/Z/N/V flags that persist between ops and feed ADC/SBB.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_SHR  = 4'd2;
  localparam logic [OPW-1:0] OP_SHL  = 4'd3;
  localparam logic [OPW-1:0] OP_AND  = 4'd4;
  localparam logic [OPW-1:0] OP_OR   = 4'd5;
  localparam logic [OPW-1:0] OP_NOT  = 4'd6;
  localparam logic [OPW-1:0] OP_XOR  = 4'd7;
  localparam logic [OPW-1:0] OP_ADC  = 4'd8;
  localparam logic [OPW-1:0] OP_SBB  = 4'd9;
  localparam logic [OPW-1:0] OP_MUL  = 4'd10;
  localparam logic [OPW-1:0] OP_DIVU = 4'd11;

  logic [1:0]       state_r;
  logic [OPW-1:0]   op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [CW-1:0]    cnt_r;

  logic             accept_s;
  logic             multi_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic             alu_keep_s;

  logic [WIDTH:0]   mul_add_s;
  logic [WIDTH:0]   div_shl_s;
  logic [WIDTH-1:0] div_sub_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] hi_nx_s;
  logic [WIDTH-1:0] lo_nx_s;
  logic             last_s;
  logic [WIDTH-1:0] fin_res_s;
  logic [WIDTH-1:0] fin_hi_s;
  logic             fin_c_s;
  logic             fin_v_s;

  assign in_ready = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
  assign accept_s = in_valid & in_ready;
  assign multi_s  = (op == OP_MUL) | (op == OP_DIVU);

  // Carry/borrow-in is the flag left by the last completed op; only ADC/SBB consume it.
  assign cin_s  = flag_c & ((op == OP_ADC) | (op == OP_SBB));
  assign sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
  assign diff_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_s};

  // Single-cycle datapath: result and C/V for every op resolved at accept.
  always_comb begin
    alu_res_s  = {WIDTH{1'b0}};
    alu_c_s    = 1'b0;
    alu_v_s    = 1'b0;
    alu_keep_s = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] != b[WIDTH-1]) & (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHR: begin
        alu_res_s = {1'b0, a[WIDTH-1:1]};
        alu_c_s   = a[0];
      end
      OP_SHL: begin
        alu_res_s = {a[WIDTH-2:0], 1'b0};
        alu_c_s   = a[WIDTH-1];
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_NOT:  alu_res_s = ~a;
      OP_XOR:  alu_res_s = a ^ b;
      OP_MUL, OP_DIVU: alu_res_s = {WIDTH{1'b0}};
      default: alu_keep_s = 1'b1;
    endcase
  end

  // MUL: shift-add with the multiplier in lo_r; DIVU: restoring divide, quotient shifts into lo_r.
  assign mul_add_s = {1'b0, hi_r} + ({(WIDTH+1){lo_r[0]}} & {1'b0, b_r});
  assign div_shl_s = {hi_r, lo_r[WIDTH-1]};
  assign div_ge_s  = div_shl_s >= {1'b0, b_r};
  assign div_sub_s = div_shl_s[WIDTH-1:0] - b_r;
  assign last_s    = (cnt_r == CW'(WIDTH - 1));

  // One iteration step of the multi-cycle ops.
  always_comb begin
    hi_nx_s = hi_r;
    lo_nx_s = lo_r;
    if (op_r == OP_MUL) begin
      hi_nx_s = mul_add_s[WIDTH:1];
      lo_nx_s = {mul_add_s[0], lo_r[WIDTH-1:1]};
    end else if (div_ge_s) begin
      hi_nx_s = div_sub_s;
      lo_nx_s = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx_s = div_shl_s[WIDTH-1:0];
      lo_nx_s = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Final result/flags of a multi-cycle op; divide-by-zero overrides the iterated values.
  always_comb begin
    fin_res_s = lo_nx_s;
    fin_hi_s  = hi_nx_s;
    fin_c_s   = 1'b0;
    fin_v_s   = 1'b0;
    if (op_r == OP_MUL) begin
      fin_c_s = |hi_nx_s;
    end else if (b_r == {WIDTH{1'b0}}) begin
      fin_res_s = {WIDTH{1'b1}};
      fin_hi_s  = a_r;
      fin_v_s   = 1'b1;
    end else begin
      fin_c_s = 1'b0;
    end
  end

  // Control FSM, operand capture, iteration registers and registered outputs/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      op_r      <= {OPW{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      result_hi <= {WIDTH{1'b0}};
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (accept_s) begin
      if (multi_s) begin
        state_r   <= ST_BUSY;
        out_valid <= 1'b0;
        op_r      <= op;
        a_r       <= a;
        b_r       <= b;
        hi_r      <= {WIDTH{1'b0}};
        lo_r      <= a;
        cnt_r     <= {CW{1'b0}};
      end else begin
        state_r   <= ST_DONE;
        out_valid <= 1'b1;
        result    <= alu_res_s;
        result_hi <= {WIDTH{1'b0}};
        flag_z    <= (alu_res_s == {WIDTH{1'b0}});
        // Reserved codes only force Z; C/N/V keep their previous values.
        flag_c    <= alu_keep_s ? flag_c : alu_c_s;
        flag_n    <= alu_keep_s ? flag_n : alu_res_s[WIDTH-1];
        flag_v    <= alu_keep_s ? flag_v : alu_v_s;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid <= 1'b0;
        end
        ST_BUSY: begin
          hi_r  <= hi_nx_s;
          lo_r  <= lo_nx_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            state_r   <= ST_DONE;
            out_valid <= 1'b1;
            result    <= fin_res_s;
            result_hi <= fin_hi_s;
            flag_c    <= fin_c_s;
            flag_z    <= (fin_res_s == {WIDTH{1'b0}});
            flag_n    <= fin_res_s[WIDTH-1];
            flag_v    <= fin_v_s;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vector table, handshake corner
// sequences, async reset mid-MUL, and randomized ops against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [3:0]    op = 4'd0;
  logic [W-1:0]  a = 16'd0;
  logic [W-1:0]  b = 16'd0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          flag_c, flag_z, flag_n, flag_v;

  int errors = 0;
  int checks = 0;

  // reference-model flag state (C, N, V survive into the next op)
  logic m_c = 1'b0;
  logic m_n = 1'b0;
  logic m_v = 1'b0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  flags;   // {C, Z, N, V}
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the op definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t   e;
    longint ua, ub, sa, sb, s, sv, cin;
    logic   c, z, n, v;
    ua  = longint'(x);
    ub  = longint'(y);
    sa  = (ua >= 32768) ? ua - 65536 : ua;
    sb  = (ub >= 32768) ? ub - 65536 : ub;
    cin = m_c ? 1 : 0;
    e.res = 16'h0; e.hi = 16'h0;
    c = 1'b0; v = 1'b0; s = 0; sv = 0;
    case (o)
      4'd0:  begin s = ua + ub;       sv = sa + sb;       c = (s > 65535); end
      4'd1:  begin s = ua - ub;       sv = sa - sb;       c = (ua < ub); end
      4'd8:  begin s = ua + ub + cin; sv = sa + sb + cin; c = (s > 65535); end
      4'd9:  begin s = ua - ub - cin; sv = sa - sb - cin; c = (ua < ub + cin); end
      4'd2:  begin e.res = 16'(ua / 2); c = (ua % 2) == 1; end
      4'd3:  begin e.res = 16'((ua * 2) % 65536); c = (ua >= 32768); end
      4'd4:  e.res = x & y;
      4'd5:  e.res = x | y;
      4'd6:  e.res = ~x;
      4'd7:  e.res = x ^ y;
      4'd10: begin s = ua * ub; e.res = 16'(s % 65536); e.hi = 16'(s / 65536); c = (s / 65536) != 0; end
      4'd11: begin
        if (ub == 0) begin e.res = 16'hFFFF; e.hi = x; v = 1'b1; end
        else begin e.res = 16'(ua / ub); e.hi = 16'(ua % ub); end
      end
      default: ;
    endcase
    if (o == 4'd0 || o == 4'd1 || o == 4'd8 || o == 4'd9) begin
      e.res = 16'(s & 64'hFFFF);
      v = (sv > 32767) || (sv < -32768);
    end
    z = (e.res == 16'h0);
    n = e.res[15];
    if (o >= 4'd12) begin
      e.res = 16'h0; e.hi = 16'h0;
      c = m_c; z = 1'b1; n = m_n; v = m_v;
    end
    e.flags = {c, z, n, v};
    return e;
  endfunction

  task automatic commit(input exp_t e);
    m_c = e.flags[3];
    m_n = e.flags[1];
    m_v = e.flags[0];
  endtask

  // One complete transaction: accept, measure latency, optional stall, compare, consume.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                        input logic [15:0] y, input int stall, input exp_t e, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check($sformatf("%s in_ready", tag), 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    for (int k = 0; k < stall; k++) @(negedge clk);
    check($sformatf("%s out_valid", tag), 32'(out_valid), 32'd1);
    check($sformatf("%s result", tag), 32'(result), 32'(e.res));
    check($sformatf("%s result_hi", tag), 32'(result_hi), 32'(e.hi));
    check($sformatf("%s flags CZNV", tag), 32'({flag_c, flag_z, flag_n, flag_v}), 32'(e.flags));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    commit(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[21];
    exp_t        e;
    exp_t        e2;
    exp_t        bb_exp[8];
    logic [3:0]  o;
    logic [15:0] x, y;
    logic [3:0]  singles[11];
    int          n;

    tbl[0]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 1};
    tbl[1]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0011, 1};
    tbl[2]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 1};
    tbl[3]  = '{4'd8,  16'h0000, 16'h0000, 16'h0001, 16'h0000, 4'b0000, 1};
    tbl[4]  = '{4'd10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1000, 17};
    tbl[5]  = '{4'd11, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 17};
    tbl[6]  = '{4'd11, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 4'b0011, 17};
    tbl[7]  = '{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b1010, 1};
    tbl[8]  = '{4'd9,  16'h0005, 16'h0003, 16'h0001, 16'h0000, 4'b0000, 1};
    tbl[9]  = '{4'd2,  16'h8001, 16'h0000, 16'h4000, 16'h0000, 4'b1000, 1};
    tbl[10] = '{4'd3,  16'h8001, 16'h0000, 16'h0002, 16'h0000, 4'b1000, 1};
    tbl[11] = '{4'd13, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b1100, 1};
    tbl[12] = '{4'd4,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000, 1};
    tbl[13] = '{4'd6,  16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 4'b0010, 1};
    tbl[14] = '{4'd7,  16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b0100, 1};
    tbl[15] = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 1};
    tbl[16] = '{4'd1,  16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 4'b1010, 1};
    tbl[17] = '{4'd9,  16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 4'b1010, 1};
    tbl[18] = '{4'd10, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0100, 17};
    tbl[19] = '{4'd5,  16'h1200, 16'h0034, 16'h1234, 16'h0000, 4'b0000, 1};
    tbl[20] = '{4'd11, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0010, 17};

    singles = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12};

    // reset state
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset result_hi", 32'(result_hi), 32'd0);
    check("reset flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle in_ready", 32'(in_ready), 32'd1);

    // directed vector table
    for (int i = 0; i < 21; i++) begin
      e.res = tbl[i].res; e.hi = tbl[i].hi; e.flags = tbl[i].flags;
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, i % 3, e, tbl[i].lat);
    end

    // held result under backpressure; a waiting op must not be accepted
    @(negedge clk);
    in_valid = 1'b1; op = 4'd1; a = 16'd3; b = 16'd5; out_ready = 1'b0;
    e = model(4'd1, 16'd3, 16'd5);
    commit(e);
    @(negedge clk);
    op = 4'd0; a = 16'd1; b = 16'd1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d result", k), 32'(result), 32'hFFFE);
      check($sformatf("hold%0d flag_c", k), 32'(flag_c), 32'd1);
      check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    e2 = model(4'd0, 16'd1, 16'd1);
    commit(e2);
    @(negedge clk);
    check("hold release out_valid", 32'(out_valid), 32'd1);
    check("hold release result", 32'(result), 32'(e2.res));
    check("hold release flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'(e2.flags));
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // back-to-back single-cycle ops, one result per clock
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check($sformatf("b2b%0d out_valid", i - 1), 32'(out_valid), 32'd1);
        check($sformatf("b2b%0d result", i - 1), 32'(result), 32'(bb_exp[i-1].res));
        check($sformatf("b2b%0d flags", i - 1), 32'({flag_c, flag_z, flag_n, flag_v}), 32'(bb_exp[i-1].flags));
      end
      if (i < 8) begin
        o = singles[$urandom_range(0, 10)];
        x = 16'($urandom); y = 16'($urandom);
        bb_exp[i] = model(o, x, y);
        commit(bb_exp[i]);
        in_valid = 1'b1; op = o; a = x; b = y;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;

    // async reset in the middle of a MUL
    e = model(4'd0, 16'hFFFF, 16'h0001);
    run_op("pre-reset add", 4'd0, 16'hFFFF, 16'h0001, 0, e, 1);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd10; a = 16'd1234; b = 16'd5678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul reset out_valid", 32'(out_valid), 32'd0);
    check("midmul reset result", 32'(result), 32'd0);
    check("midmul reset result_hi", 32'(result_hi), 32'd0);
    check("midmul reset flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
    m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("no stale MUL output", 32'(n), 32'd0);
    e = model(4'd8, 16'h0000, 16'h0000);
    run_op("post-reset adc", 4'd8, 16'h0000, 16'h0000, 0, e, 1);

    // randomized ops with random stalls
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = 16'($urandom);
      if (o == 4'd11 && $urandom_range(0, 4) == 0) y = 16'h0000;
      if ($urandom_range(0, 7) == 0) x = 16'hFFFF;
      e = model(o, x, y);
      run_op($sformatf("rnd%0d op%0d", i, o), o, x, y, $urandom_range(0, 3), e,
             (o == 4'd10 || o == 4'd11) ? 17 : 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
